// File: rtl/add_acc_pipe.sv
// Operand-staging / result-buffering stage around a 32-bit carry-lookahead adder.
// One S1 op register feeds the adder; results land in a 2-entry FIFO; a running accumulator lives at S1.

// 4-bit lookahead group: local carries plus group generate/propagate for the next level.
module add_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       g_o,
  output logic       p_o
);
  logic [3:0] g, p, c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign s_o  = p ^ c;

  // Group G/P must not depend on c_i so the second level stays acyclic.
  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;
endmodule

// 32-bit unsigned adder, Sum = A + B with carry-out in Sum[32], carry-in fixed at 0.
module add_tc_16_16 #(
  parameter int NUM_GRP = 8
) (
  input  logic [4*NUM_GRP-1:0] A,
  input  logic [4*NUM_GRP-1:0] B,
  output logic [4*NUM_GRP:0]   Sum
);
  logic [NUM_GRP-1:0] gg, gp;
  logic [NUM_GRP:0]   gc;

  add_cla4 u_grp [NUM_GRP-1:0] (
    .a_i (A),
    .b_i (B),
    .c_i (gc[NUM_GRP-1:0]),
    .s_o (Sum[4*NUM_GRP-1:0]),
    .g_o (gg),
    .p_o (gp)
  );

  always_comb begin
    gc[0] = 1'b0;
    for (int i = 0; i < NUM_GRP; i++)
      gc[i+1] = gg[i] | (gp[i] & gc[i]);
  end

  assign Sum[4*NUM_GRP] = gc[NUM_GRP];
endmodule

module add_acc_pipe #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_sum,
  output logic [31:0] acc_value,
  output logic        acc_ovf
);
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ACC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // S1 operation register
  logic        s1_vld_q, s1_vld_d;
  op_e         s1_op_q, s1_op_d;
  logic [31:0] s1_a_q, s1_a_d;
  logic [31:0] s1_b_q, s1_b_d;

  // accumulator
  logic [31:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;

  // result FIFO
  logic [32:0] fifo_q [FIFO_DEPTH];
  logic [32:0] fifo_d [FIFO_DEPTH];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        producing, fifo_full, commit, push, pop, accept;
  logic [31:0] add_a, add_b;
  logic [32:0] sum;

  assign producing = (s1_op_q == OP_ADD) || (s1_op_q == OP_ACC);
  assign fifo_full = (cnt_q == 2'(FIFO_DEPTH));
  // No full-bypass: a pop in the same cycle never frees room for a push.
  assign commit    = s1_vld_q && (!producing || !fifo_full);
  assign push      = commit && producing;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = !s1_vld_q || commit;
  assign accept    = in_valid && in_ready;

  assign add_a = (s1_op_q == OP_ACC) ? acc_q  : s1_a_q;
  assign add_b = (s1_op_q == OP_ACC) ? s1_a_q : s1_b_q;

  add_tc_16_16 u_add (
    .A   (add_a),
    .B   (add_b),
    .Sum (sum)
  );

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_op_d  = s1_op_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_op_d  = op_e'(in_op);
      s1_a_d   = in_a;
      s1_b_d   = in_b;
    end else if (commit) begin
      s1_vld_d = 1'b0;
    end
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (commit) begin
      unique case (s1_op_q)
        OP_ACC: begin
          acc_d = sum[31:0];
          ovf_d = ovf_q | sum[32];
        end
        OP_CLR: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        OP_LOAD: begin
          acc_d = s1_a_q;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = sum;
      wptr_d         = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= OP_ADD;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_op_q  <= s1_op_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      fifo_q   <= fifo_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign out_sum   = out_valid ? fifo_q[rptr_q] : '0;
  assign acc_value = acc_q;
  assign acc_ovf   = ovf_q;
endmodule

// File: tb/tb_add_acc_pipe.sv
// Directed table + corner sequences + random streaming against a transaction-order model.
module tb_add_acc_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [32:0] out_sum;
  logic [31:0] acc_value;
  logic        acc_ovf;

  add_acc_pipe #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .acc_value(acc_value), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic [31:0] macc = '0;
  logic        movf = 1'b0;
  logic [32:0] msum;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: ops take effect in acceptance order.
  always @(negedge clk) begin
    if (rst === 1'b0 && in_valid && in_ready) begin
      case (in_op)
        2'd0: exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
        2'd1: begin
          msum = {1'b0, macc} + {1'b0, in_a};
          exp_q.push_back(msum);
          macc = msum[31:0];
          if (msum[32]) movf = 1'b1;
        end
        2'd2: begin macc = '0;   movf = 1'b0; end
        default: begin macc = in_a; movf = 1'b0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid && out_ready) begin
      got_q.push_back(out_sum);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h, expected no output", out_sum);
      end else begin
        chk("pop_order", 64'(out_sum), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge rst) begin
    exp_q.delete();
    got_q.delete();
    macc = '0;
    movf = 1'b0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded); returns at posedge+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected acceptance");
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        push;
    logic [32:0] sum;
    logic [31:0] acc;
    logic        ovf;
  } vec_t;

  vec_t vt[11];

  initial begin
    int acc_n, cyc_n, r;

    vt[0]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h1_0000_0000, 32'h0000_0000, 1'b0};
    vt[1]  = '{2'd3, 32'h8000_0000, 32'h0,         1'b0, 33'h0,           32'h8000_0000, 1'b0};
    vt[2]  = '{2'd1, 32'h8000_0000, 32'h0,         1'b1, 33'h1_0000_0000, 32'h0000_0000, 1'b1};
    vt[3]  = '{2'd1, 32'h0000_0005, 32'h0,         1'b1, 33'h0_0000_0005, 32'h0000_0005, 1'b1};
    vt[4]  = '{2'd0, 32'h1234_5678, 32'h1111_1111, 1'b1, 33'h0_2345_6789, 32'h0000_0005, 1'b1};
    vt[5]  = '{2'd1, 32'hFFFF_FFFB, 32'h0,         1'b1, 33'h1_0000_0000, 32'h0000_0000, 1'b1};
    vt[6]  = '{2'd2, 32'hAAAA_AAAA, 32'h0,         1'b0, 33'h0,           32'h0000_0000, 1'b0};
    vt[7]  = '{2'd1, 32'hFFFF_FFFF, 32'h0,         1'b1, 33'h0_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[8]  = '{2'd1, 32'h0000_0001, 32'h0,         1'b1, 33'h1_0000_0000, 32'h0000_0000, 1'b1};
    vt[9]  = '{2'd3, 32'hDEAD_BEEF, 32'h0,         1'b0, 33'h0,           32'hDEAD_BEEF, 1'b0};
    vt[10] = '{2'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0,           32'hDEAD_BEEF, 1'b0};

    in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
    rst = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum",   64'(out_sum),   64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_acc",       64'(acc_value), 64'(0));
    chk("rst_ovf",       64'(acc_ovf),   64'(0));
    @(negedge clk) rst = 1'b0;
    cyc(1);

    // Table: one op at a time, result/accumulator checked one cycle after acceptance.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(1));
      cyc(1);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].push));
      if (vt[i].push) chk($sformatf("vec%0d_sum", i), 64'(out_sum), 64'(vt[i].sum));
      chk($sformatf("vec%0d_acc", i), 64'(acc_value), 64'(vt[i].acc));
      chk($sformatf("vec%0d_ovf", i), 64'(acc_ovf),   64'(vt[i].ovf));
      cyc(1);
    end

    // LOAD, ACC, ACC issued back-to-back: no forwarding hazard.
    got_q.delete();
    issue(2'd3, 32'h8000_0000, 32'h0);
    issue(2'd1, 32'h8000_0000, 32'h0);
    issue(2'd1, 32'h0000_0005, 32'h0);
    cyc(4);
    @(negedge clk);
    chk("b2b_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      chk("b2b_sum0", 64'(got_q[0]), 64'h1_0000_0000);
      chk("b2b_sum1", 64'(got_q[1]), 64'h0_0000_0005);
    end
    chk("b2b_acc", 64'(acc_value), 64'h5);
    chk("b2b_ovf", 64'(acc_ovf),   64'h1);
    cyc(1);

    // Backpressure: third producing op stalls in S1.
    got_q.delete();
    out_ready = 1'b0;
    issue(2'd0, 32'd1, 32'd1);
    issue(2'd0, 32'd2, 32'd2);
    issue(2'd0, 32'd3, 32'd3);
    @(negedge clk);
    chk("bp_in_ready",  64'(in_ready),  64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_head",      64'(out_sum),   64'(2));
    cyc(3);
    @(negedge clk);
    chk("bp_head_stable", 64'(out_sum),  64'(2));
    chk("bp_still_stall", 64'(in_ready), 64'(0));
    cyc(1);
    out_ready = 1'b1;
    cyc(5);
    @(negedge clk);
    chk("bp_count", 64'(got_q.size()), 64'(3));
    if (got_q.size() == 3) begin
      chk("bp_out0", 64'(got_q[0]), 64'(2));
      chk("bp_out1", 64'(got_q[1]), 64'(4));
      chk("bp_out2", 64'(got_q[2]), 64'(6));
    end
    cyc(1);

    // CLR with the FIFO full.
    issue(2'd3, 32'hFFFF_FFFF, 32'h0);
    issue(2'd1, 32'h0000_0002, 32'h0);
    cyc(3);
    @(negedge clk);
    chk("pre_clr_acc", 64'(acc_value), 64'h1);
    chk("pre_clr_ovf", 64'(acc_ovf),   64'h1);
    cyc(1);
    out_ready = 1'b0;
    issue(2'd0, 32'd1, 32'd1);
    issue(2'd0, 32'd2, 32'd2);
    issue(2'd2, 32'd0, 32'd0);
    cyc(1);
    @(negedge clk);
    chk("clr_full_acc",      64'(acc_value), 64'(0));
    chk("clr_full_ovf",      64'(acc_ovf),   64'(0));
    chk("clr_full_head",     64'(out_sum),   64'(2));
    chk("clr_full_in_ready", 64'(in_ready),  64'(1));
    cyc(1);

    // Reset mid-cycle with a full FIFO and an ACC stuck in S1.
    issue(2'd3, 32'h0000_1234, 32'h0);
    issue(2'd1, 32'h0000_0003, 32'h0);
    @(negedge clk);
    chk("pre_rst_acc",      64'(acc_value), 64'h1234);
    chk("pre_rst_in_ready", 64'(in_ready),  64'(0));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_sum",   64'(out_sum),   64'(0));
    chk("arst_acc",       64'(acc_value), 64'(0));
    chk("arst_ovf",       64'(acc_ovf),   64'(0));
    chk("arst_in_ready",  64'(in_ready),  64'(1));
    @(negedge clk) rst = 1'b0;
    cyc(1);
    out_ready = 1'b1;
    issue(2'd0, 32'd7, 32'd8);
    cyc(2);
    @(negedge clk);
    chk("post_rst_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) chk("post_rst_sum", 64'(got_q[0]), 64'h0_0000_000F);
    cyc(1);

    // Random streaming with random backpressure.
    acc_n = 0;
    cyc_n = 0;
    while (acc_n < 1000 && cyc_n < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      in_op = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      in_a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      in_b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc_n++;
      cyc(1);
      cyc_n++;
    end
    in_valid = 1'b0;
    if (acc_n < 1000) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: accepted %0d, expected 1000", acc_n);
    end
    out_ready = 1'b1;
    cyc(10);
    @(negedge clk);
    chk("stream_drained",   64'(exp_q.size()), 64'(0));
    chk("stream_out_valid", 64'(out_valid),    64'(0));
    chk("stream_acc",       64'(acc_value),    64'(macc));
    chk("stream_ovf",       64'(acc_ovf),      64'(movf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add_acc_pipe.md
# add_acc_pipe

Pipelined operand-staging and result-buffering stage wrapped around the 32-bit carry-lookahead adder (`add_tc_16_16`, Sum = A + B, 33 bits). It accepts operation requests over a valid/ready handshake and registers the operands that drive the adder. It keeps a 32-bit running accumulator with a sticky overflow flag, and captures 33-bit results into a 2-entry output FIFO drained by a valid/ready consumer. The adder itself stays combinational and is instantiated inside this block.

## Interface
Parameters:
- FIFO_DEPTH, 2, output FIFO entries; the only supported value is 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock; all state changes on the rising edge.
  - rst  in  1  asynchronous, active-high reset.
- Request side:
  - in_valid  in  1  request present.
  - in_ready  out  1  block can accept a request this cycle.
  - in_op  in  2  00 ADD, 01 ACC, 10 CLR, 11 LOAD.
  - in_a  in  32  operand A, unsigned.
  - in_b  in  32  operand B; used by ADD only.
- Result side:
  - out_valid  out  1  FIFO head valid.
  - out_ready  in  1  consumer accepts the head.
  - out_sum  out  33  FIFO head result, {carry, sum[31:0]}.
- Status:
  - acc_value  out  32  current accumulator.
  - acc_ovf  out  1  sticky: an ACC produced carry-out since the last CLR or LOAD.

## Operation
- **Stage 1 (S1) register:** holds s1_valid, op, a and b. The adder inputs are driven from the S1 registers only.
  - ADD uses a and b.
  - ACC uses acc_value and a.
  - Cin is tied to 0.
- **Accepting a request:** a request is accepted when in_valid && in_ready; it is then loaded into S1.
  - in_ready = !s1_valid || s1_commit. This is a combinational path from S1 and FIFO state only; out_ready never reaches in_ready.
- **S1 commit:**
  - Producing ops (ADD, ACC) commit when s1_valid && fifo_count < 2.
  - Non-producing ops (CLR, LOAD) commit when s1_valid, unconditionally.
- **Effects at commit:**
  - ADD: push the adder Sum (33 bits). Accumulator unchanged.
  - ACC: push Sum. acc_value <= Sum[31:0]. If Sum[32], set acc_ovf.
  - CLR: acc_value <= 0, acc_ovf <= 0. Nothing is pushed.
  - LOAD: acc_value <= a, acc_ovf <= 0. Nothing is pushed.
- **Ordering:** ops commit in acceptance order. The accumulator is read and written only at S1, so back-to-back ACC/LOAD/CLR need no forwarding: the next op sees the updated accumulator.
- **FIFO:** 2 entries with a 0..2 count.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - A push is never accepted at count 2, even with a simultaneous pop. There is no full-bypass.
  - out_valid = count != 0. out_sum = head entry and is held stable while out_valid && !out_ready.
- **Arithmetic:** all values are unsigned modulo 2^32. The carry appears only in out_sum[32] and acc_ovf. Sign interpretation is left to the consumer.
- **Reset, asynchronous, may occur mid-operation:**
  - s1_valid=0; FIFO count=0, and pointers cleared.
  - acc_value=0, acc_ovf=0.
  - Outputs during reset: out_valid=0, out_sum=0, in_ready=1.
  - In-flight requests and buffered results are discarded.

## Timing
- Request accepted at edge k:
  - S1 holds it during cycle k..k+1.
  - Commit at edge k+1 if the FIFO has space.
  - out_valid=1 from edge k+1 when the FIFO was empty. Minimum latency is 1 cycle from acceptance edge to out_valid.
- Throughput is 1 op per cycle while out_ready=1 continuously: FIFO count settles at ≤1 and in_ready stays 1.
- With out_ready=0:
  - Two producing ops fill the FIFO.
  - A third is accepted into S1 and stalls there.
  - in_ready drops until a pop frees an entry.
- A stalled CLR/LOAD never blocks, because these ops always commit.
- acc_value and acc_ovf update on the commit edge and are visible the following cycle.

## Test plan
1. **ADD:** ADD a=0xFFFF_FFFF b=0x0000_0001 with out_ready=1 -> one cycle later out_valid=1, out_sum=0x1_0000_0000; acc_value stays 0.
2. **LOAD then ACC:** LOAD 0x8000_0000, then ACC a=0x8000_0000, then ACC a=0x0000_0005, all back-to-back:
   - out_sum sequence 0x1_0000_0000, 0x0_0000_0005.
   - Final acc_value=0x0000_0005, acc_ovf=1.
3. **Backpressure:** hold out_ready=0 and issue ADDs 1+1, 2+2, 3+3:
   - The FIFO holds 2, 4; in_ready=0 with 3+3 stalled in S1.
   - Raise out_ready -> outputs 2, 4, 6 in order, with no loss or duplication and out_sum stable while stalled.
4. **CLR while FIFO full:** with the FIFO full (out_ready=0), issue CLR -> CLR commits, acc_value=0 and acc_ovf=0 next cycle, and no FIFO push occurs.
5. **Reset mid-operation:** with 2 FIFO entries and a pending ACC in S1, assert rst asynchronously mid-cycle:
   - Immediately out_valid=0, out_sum=0, acc_value=0, acc_ovf=0, in_ready=1.
   - After release, ADD 7+8 -> out_sum=0x0_0000_000F.
6. **Streaming:** random streaming of 1000 mixed ops with random out_ready -> scoreboard matches a reference model on out_sum order and on acc_value/acc_ovf.
